icb_mux_arb5: RTL and testbench

ICB_MUX_ARB5 -- requirements
Module: icb_mux_arb5

---
 rtl/icb_arb_pkg.sv | 18 +
 rtl/rr_pick5.sv | 27 ++
 rtl/icb_mux_arb5.sv | 128 ++++++++++++
 tb/tb_icb_mux_arb5.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icb_arb_pkg.sv
// Shared definitions for the five-port ICB mux arbiter: port count, "no owner" select code,
// arbiter state encoding and the round-robin successor helper.
package icb_arb_pkg;

  localparam int NUM_SLV = 5;
  localparam logic [2:0] SEL_NONE = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_DRAIN
  } arb_state_t;

  function automatic logic [2:0] rr_next(input logic [2:0] cur);
    return (cur >= 3'(NUM_SLV - 1)) ? 3'd0 : cur + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick5.sv
// Round-robin picker: first requester after last_owner, wrapping modulo 5; zero latency, no state.
// found is low and idx is SEL_NONE when nobody requests.
module rr_pick5
  import icb_arb_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] last_owner,
  output logic [2:0] idx,
  output logic       found
);

  logic [2:0] cand;

  always_comb begin
    idx   = SEL_NONE;
    found = 1'b0;
    cand  = rr_next(last_owner);
    for (int i = 0; i < NUM_SLV; i++) begin
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
      cand = rr_next(cand);
    end
  end

endmodule

// File: rtl/icb_mux_arb5.sv
// Tenure arbiter for a 5:1 ICB mux: one cycle from request to grant, quota-bounded tenures,
// cmd gated combinationally by a registered open flag while responses/write beats are in flight.
module icb_mux_arb5
  import icb_arb_pkg::*;
#(
  parameter int QUANTUM = 4,
  parameter int MAX_OST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic       mux_cmd_valid,
  input  logic       mux_cmd_read,
  input  logic       bus_cmd_ready,
  output logic       bus_cmd_valid,
  output logic       mux_cmd_ready,
  input  logic       w_valid,
  input  logic       w_ready,
  input  logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [2:0] sel,
  output logic [4:0] gnt_oh,
  output logic       busy,
  output logic       err_unexp_rsp
);

  localparam logic [3:0] QUANTUM_C = 4'(QUANTUM);
  localparam logic [3:0] MAX_OST_C = 4'(MAX_OST);

  arb_state_t state, state_nxt;
  logic [2:0] owner, owner_nxt, last_owner, last_owner_nxt;
  logic [3:0] ost, ost_nxt, wr_pend, wr_pend_nxt, quota, quota_nxt;
  logic       cmd_open, cmd_hs, rsp_hs, w_hs, wr_inc, err_nxt;
  logic [2:0] pick_idx;
  logic       pick_found;

  rr_pick5 u_pick (
    .req        (req),
    .last_owner (last_owner),
    .idx        (pick_idx),
    .found      (pick_found)
  );

  assign bus_cmd_valid = mux_cmd_valid & cmd_open;
  assign mux_cmd_ready = bus_cmd_ready & cmd_open;
  assign cmd_hs        = bus_cmd_valid & bus_cmd_ready;
  assign rsp_hs        = rsp_valid & rsp_ready;
  assign w_hs          = w_valid & w_ready;
  assign wr_inc        = cmd_hs & ~mux_cmd_read;

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    quota_nxt      = quota;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nxt = ST_GRANT;
          owner_nxt = pick_idx;
        end
      end
      ST_GRANT: begin
        if (cmd_hs) begin
          quota_nxt = quota + 4'd1;
          if (quota_nxt == QUANTUM_C) state_nxt = ST_DRAIN;
        end else if (!req[owner]) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // sel stays on the owner until every response and write beat has been seen
        if (ost == 4'd0 && wr_pend == 4'd0) begin
          state_nxt      = ST_IDLE;
          last_owner_nxt = owner;
          quota_nxt      = 4'd0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ost_nxt     = ost;
    wr_pend_nxt = wr_pend;
    err_nxt     = 1'b0;
    if (cmd_hs && !rsp_hs) begin
      ost_nxt = ost + 4'd1;
    end else if (rsp_hs && !cmd_hs) begin
      if (ost == 4'd0) err_nxt = 1'b1;
      else             ost_nxt = ost - 4'd1;
    end
    if (wr_inc && !w_hs) begin
      wr_pend_nxt = wr_pend + 4'd1;
    end else if (w_hs && !wr_inc && wr_pend != 4'd0) begin
      wr_pend_nxt = wr_pend - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      owner         <= 3'd0;
      last_owner    <= 3'(NUM_SLV - 1);
      quota         <= 4'd0;
      ost           <= 4'd0;
      wr_pend       <= 4'd0;
      cmd_open      <= 1'b0;
      sel           <= SEL_NONE;
      gnt_oh        <= 5'd0;
      busy          <= 1'b0;
      err_unexp_rsp <= 1'b0;
    end else begin
      state         <= state_nxt;
      owner         <= owner_nxt;
      last_owner    <= last_owner_nxt;
      quota         <= quota_nxt;
      ost           <= ost_nxt;
      wr_pend       <= wr_pend_nxt;
      cmd_open      <= (state_nxt == ST_GRANT) && (ost_nxt < MAX_OST_C) && (wr_pend_nxt < MAX_OST_C);
      sel           <= (state_nxt == ST_IDLE) ? SEL_NONE : owner_nxt;
      gnt_oh        <= (state_nxt == ST_IDLE) ? 5'd0 : (5'd1 << owner_nxt);
      busy          <= (state_nxt != ST_IDLE);
      err_unexp_rsp <= err_nxt;
    end
  end

endmodule

// File: tb/tb_icb_mux_arb5.sv
// Directed bench for icb_mux_arb5: expected owners of each cmd handshake are queued by the
// stimulus and popped by an independent monitor; cycle-exact timing is checked inline.
module tb_icb_mux_arb5;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req, req2;
  logic       mux_cmd_valid, mux_cmd_read, bus_cmd_ready;
  logic       w_valid, w_ready, rsp_valid, rsp_ready;
  logic       bus_cmd_valid, mux_cmd_ready, busy, err_unexp_rsp;
  logic [2:0] sel;
  logic [4:0] gnt_oh;
  logic       bus_cmd_valid2, mux_cmd_ready2, busy2, err2;
  logic [2:0] sel2;
  logic [4:0] gnt_oh2;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;
  int err_cnt = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  icb_mux_arb5 dut (
    .clk(clk), .rst(rst), .req(req),
    .mux_cmd_valid(mux_cmd_valid), .mux_cmd_read(mux_cmd_read),
    .bus_cmd_ready(bus_cmd_ready), .bus_cmd_valid(bus_cmd_valid), .mux_cmd_ready(mux_cmd_ready),
    .w_valid(w_valid), .w_ready(w_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .sel(sel), .gnt_oh(gnt_oh), .busy(busy), .err_unexp_rsp(err_unexp_rsp)
  );

  icb_mux_arb5 #(.QUANTUM(4), .MAX_OST(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2),
    .mux_cmd_valid(mux_cmd_valid), .mux_cmd_read(mux_cmd_read),
    .bus_cmd_ready(bus_cmd_ready), .bus_cmd_valid(bus_cmd_valid2), .mux_cmd_ready(mux_cmd_ready2),
    .w_valid(w_valid), .w_ready(w_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .sel(sel2), .gnt_oh(gnt_oh2), .busy(busy2), .err_unexp_rsp(err2)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each handshake on the main DUT must match the next queued owner.
  always @(negedge clk) begin
    if (!rst && bus_cmd_valid && bus_cmd_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL hs_unexpected: handshake with sel=%0d, expected none", sel);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        chk("hs_owner", int'(sel), int'(e));
        chk("hs_gnt_oh", int'(gnt_oh), int'(5'd1 << e));
      end
    end
    if (err_unexp_rsp) err_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0; req2 = '0;
    mux_cmd_valid = 1'b0; mux_cmd_read = 1'b0; bus_cmd_ready = 1'b0;
    w_valid = 1'b0; w_ready = 1'b0; rsp_valid = 1'b0; rsp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // One cmd on the main DUT; returns at posedge+1 right after the handshake edge.
  task automatic do_cmd(input logic rd, input logic [2:0] owner);
    bit got = 0;
    mux_cmd_valid = 1'b1;
    mux_cmd_read  = rd;
    bus_cmd_ready = 1'b1;
    exp_q.push_back(owner);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus_cmd_valid && bus_cmd_ready) got = 1;
      step();
    end
    mux_cmd_valid = 1'b0;
    if (!got) chk("cmd_timeout", 0, 1);
  endtask

  task automatic rsp_pulse();
    rsp_valid = 1'b1;
    step();
    rsp_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target, input string name);
    int n = 0;
    while (hs_cnt < target && n < 60) begin
      step();
      n++;
    end
    if (hs_cnt < target) chk(name, hs_cnt, target);
  endtask

  task automatic count_hs2(input int cycles, output int c);
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus_cmd_valid2 && bus_cmd_ready) c++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, e0, c;

    // Reset state
    do_reset();
    mux_cmd_valid = 1'b1; bus_cmd_ready = 1'b1;
    @(negedge clk);
    chk("rst_sel", int'(sel), 7);
    chk("rst_gnt_oh", int'(gnt_oh), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_unexp_rsp), 0);
    chk("rst_bus_cmd_valid", int'(bus_cmd_valid), 0);
    chk("rst_mux_cmd_ready", int'(mux_cmd_ready), 0);
    step();
    mux_cmd_valid = 1'b0; bus_cmd_ready = 1'b0;

    // Single owner, three reads each answered, then drop
    h0 = hs_cnt; e0 = err_cnt;
    req = 5'b00001;
    @(negedge clk);
    chk("a_sel_before", int'(sel), 7);
    step();
    @(negedge clk);
    chk("a_sel_grant", int'(sel), 0);
    chk("a_gnt_oh", int'(gnt_oh), 1);
    chk("a_busy", int'(busy), 1);
    step();
    for (int k = 0; k < 3; k++) begin
      do_cmd(1'b1, 3'd0);
      rsp_pulse();
    end
    req = 5'b00000;
    @(negedge clk);
    chk("a_sel_drop_n", int'(sel), 0);
    step();
    @(negedge clk);
    chk("a_sel_drain", int'(sel), 0);
    chk("a_busy_drain", int'(busy), 1);
    step();
    @(negedge clk);
    chk("a_sel_idle", int'(sel), 7);
    chk("a_busy_idle", int'(busy), 0);
    chk("a_hs_count", hs_cnt - h0, 3);
    chk("a_err_none", err_cnt - e0, 0);
    step();

    // Round robin over 0,2,4 with quantum 4
    do_reset();
    h0 = hs_cnt; e0 = err_cnt;
    req = 5'b10101;
    mux_cmd_valid = 1'b1; mux_cmd_read = 1'b1; bus_cmd_ready = 1'b1;
    foreach (exp_q[i]) chk("b_queue_clean", 1, 0);
    for (int k = 0; k < 4; k++) exp_q.push_back(3'd0);
    for (int k = 0; k < 4; k++) exp_q.push_back(3'd2);
    for (int k = 0; k < 4; k++) exp_q.push_back(3'd4);
    for (int k = 0; k < 4; k++) exp_q.push_back(3'd0);
    for (int t = 0; t < 4; t++) begin
      wait_hs(h0 + 4 * (t + 1), "b_tenure_timeout");
      if (t == 3) begin
        req = 5'b00000;
        mux_cmd_valid = 1'b0;
      end
      rsp_valid = 1'b1;
      repeat (4) step();
      rsp_valid = 1'b0;
    end
    repeat (3) step();
    @(negedge clk);
    chk("b_hs_total", hs_cnt - h0, 16);
    chk("b_queue_empty", exp_q.size(), 0);
    chk("b_busy_end", int'(busy), 0);
    chk("b_err_none", err_cnt - e0, 0);
    step();

    // Outstanding limit of 2 on the second instance
    do_reset();
    req2 = 5'b00001;
    mux_cmd_valid = 1'b1; mux_cmd_read = 1'b1; bus_cmd_ready = 1'b1;
    count_hs2(8, c);
    chk("c_hs_at_limit", c, 2);
    @(negedge clk);
    chk("c_valid_blocked", int'(bus_cmd_valid2), 0);
    chk("c_ready_blocked", int'(mux_cmd_ready2), 0);
    chk("c_sel_held", int'(sel2), 0);
    step();
    rsp_pulse();
    count_hs2(6, c);
    chk("c_third_cmd", c, 1);
    req2 = 5'b00000;
    mux_cmd_valid = 1'b0;
    step();

    // Writes with data held back, then drain
    do_reset();
    h0 = hs_cnt; e0 = err_cnt;
    req = 5'b00001;
    w_valid = 1'b1; w_ready = 1'b0;
    do_cmd(1'b0, 3'd0);
    do_cmd(1'b0, 3'd0);
    req = 5'b00000;
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("d_sel_hold", int'(sel), 0);
      chk("d_busy_hold", int'(busy), 1);
      step();
    end
    rsp_valid = 1'b1;
    step();
    step();
    rsp_valid = 1'b0;
    @(negedge clk);
    chk("d_busy_wr_pending", int'(busy), 1);
    step();
    w_ready = 1'b1;
    step();
    step();
    w_ready = 1'b0; w_valid = 1'b0;
    @(negedge clk);
    chk("d_sel_last_drain", int'(sel), 0);
    chk("d_busy_last_drain", int'(busy), 1);
    step();
    @(negedge clk);
    chk("d_sel_idle", int'(sel), 7);
    chk("d_busy_idle", int'(busy), 0);
    chk("d_hs_count", hs_cnt - h0, 2);
    chk("d_err_none", err_cnt - e0, 0);
    step();

    // Unexpected response in IDLE
    e0 = err_cnt;
    rsp_pulse();
    @(negedge clk);
    chk("e_err_pulse", int'(err_unexp_rsp), 1);
    chk("e_ost_zero", int'(dut.ost), 0);
    step();
    @(negedge clk);
    chk("e_err_cleared", int'(err_unexp_rsp), 0);
    chk("e_err_once", err_cnt - e0, 1);
    step();

    // Reset mid-tenure with three reads outstanding
    do_reset();
    req = 5'b00010;
    for (int k = 0; k < 3; k++) do_cmd(1'b1, 3'd1);
    @(negedge clk);
    chk("f_ost_three", int'(dut.ost), 3);
    chk("f_sel_owner", int'(sel), 1);
    step();
    e0 = err_cnt;
    rst = 1'b1;
    req = 5'b00011;
    step();
    @(negedge clk);
    chk("f_sel_reset", int'(sel), 7);
    chk("f_busy_reset", int'(busy), 0);
    chk("f_ost_reset", int'(dut.ost), 0);
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("f_new_owner", int'(sel), 0);
    chk("f_new_gnt", int'(gnt_oh), 1);
    chk("f_err_none", err_cnt - e0, 0);
    chk("f_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
